// File: rtl/ga_pkg.sv
// Shared types for the GA datapath: chromosome/fitness widths and the
// tournament selector state encoding.
package ga_pkg;

    localparam int CHROM_W = 8;
    localparam int FIT_W   = 27;

    typedef logic signed [CHROM_W-1:0] chrom_t;
    typedef logic signed [FIT_W-1:0]   fitness_t;

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_OUT    = 2'd2
    } sel_state_t;

endpackage

// File: rtl/tournament_cmp.sv
// Combinational two-way fitness compare. Candidate A wins ties unless
// STRICT is set, in which case A must be strictly better to win.
module tournament_cmp #(
    parameter int CHROM_W  = 8,
    parameter int FIT_W    = 27,
    parameter bit MAXIMIZE = 1'b1,
    parameter bit STRICT   = 1'b0
) (
    input  logic signed [CHROM_W-1:0] a_chrom,
    input  logic signed [FIT_W-1:0]   a_fit,
    input  logic signed [CHROM_W-1:0] b_chrom,
    input  logic signed [FIT_W-1:0]   b_fit,
    output logic signed [CHROM_W-1:0] win_chrom,
    output logic signed [FIT_W-1:0]   win_fit
);
    import ga_pkg::*;

    logic a_wins;

    // Decide whether A beats B under the configured direction and tie rule.
    always_comb begin
        a_wins = 1'b0;
        if (MAXIMIZE) begin
            a_wins = STRICT ? (a_fit > b_fit) : (a_fit >= b_fit);
        end else begin
            a_wins = STRICT ? (a_fit < b_fit) : (a_fit <= b_fit);
        end
    end

    assign win_chrom = a_wins ? a_chrom : b_chrom;
    assign win_fit   = a_wins ? a_fit   : b_fit;

endmodule

// File: rtl/tournament_select.sv
// Binary tournament selector: one tournament per accepted scored pair,
// two winners form a parent pair for crossover, plus a best-so-far tracker.
module tournament_select #(
    parameter int CHROM_W  = 8,
    parameter int FIT_W    = 27,
    parameter bit MAXIMIZE = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [CHROM_W-1:0] chrom1,
    input  logic signed [CHROM_W-1:0] chrom2,
    input  logic signed [FIT_W-1:0]   fitness1,
    input  logic signed [FIT_W-1:0]   fitness2,
    output logic                      par_valid,
    input  logic                      par_ready,
    output logic signed [CHROM_W-1:0] parent1,
    output logic signed [CHROM_W-1:0] parent2,
    output logic [15:0]               pair_count,
    input  logic                      clear_best,
    output logic                      best_valid,
    output logic signed [CHROM_W-1:0] best_chrom,
    output logic signed [FIT_W-1:0]   best_fitness
);
    import ga_pkg::*;

    sel_state_t                state_q, state_d;
    logic                      par_valid_q, par_valid_d;
    logic signed [CHROM_W-1:0] parent1_q, parent1_d;
    logic signed [CHROM_W-1:0] parent2_q, parent2_d;
    logic [15:0]               pair_count_q, pair_count_d;
    logic                      best_valid_q, best_valid_d;
    logic signed [CHROM_W-1:0] best_chrom_q, best_chrom_d;
    logic signed [FIT_W-1:0]   best_fitness_q, best_fitness_d;

    logic                      accept;
    logic signed [CHROM_W-1:0] win_chrom;
    logic signed [FIT_W-1:0]   win_fit;
    logic signed [CHROM_W-1:0] keep_chrom;
    logic signed [FIT_W-1:0]   keep_fit;

    assign in_ready = (state_q != S_OUT);
    assign accept   = in_valid && in_ready;

    // The tournament itself: ties go to chrom1.
    tournament_cmp #(
        .CHROM_W (CHROM_W),
        .FIT_W   (FIT_W),
        .MAXIMIZE(MAXIMIZE),
        .STRICT  (1'b0)
    ) u_tournament (
        .a_chrom  (chrom1),
        .a_fit    (fitness1),
        .b_chrom  (chrom2),
        .b_fit    (fitness2),
        .win_chrom(win_chrom),
        .win_fit  (win_fit)
    );

    // Best-vs-winner: the new winner must be strictly better to displace the incumbent.
    tournament_cmp #(
        .CHROM_W (CHROM_W),
        .FIT_W   (FIT_W),
        .MAXIMIZE(MAXIMIZE),
        .STRICT  (1'b1)
    ) u_best (
        .a_chrom  (win_chrom),
        .a_fit    (win_fit),
        .b_chrom  (best_chrom_q),
        .b_fit    (best_fitness_q),
        .win_chrom(keep_chrom),
        .win_fit  (keep_fit)
    );

    // Collect two winners, hold the pair until downstream takes it.
    always_comb begin
        state_d      = state_q;
        par_valid_d  = par_valid_q;
        parent1_d    = parent1_q;
        parent2_d    = parent2_q;
        pair_count_d = pair_count_q;
        case (state_q)
            S_FIRST: begin
                if (accept) begin
                    parent1_d = win_chrom;
                    state_d   = S_SECOND;
                end
            end
            S_SECOND: begin
                if (accept) begin
                    parent2_d   = win_chrom;
                    par_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (par_valid_q && par_ready) begin
                    par_valid_d  = 1'b0;
                    pair_count_d = pair_count_q + 16'd1;
                    state_d      = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    // Best tracker: a clear in the same cycle as an accept lets the current winner load.
    always_comb begin
        best_valid_d   = best_valid_q;
        best_chrom_d   = best_chrom_q;
        best_fitness_d = best_fitness_q;
        if (clear_best) begin
            best_valid_d = 1'b0;
        end
        if (accept) begin
            best_valid_d = 1'b1;
            if (clear_best || !best_valid_q) begin
                best_chrom_d   = win_chrom;
                best_fitness_d = win_fit;
            end else begin
                best_chrom_d   = keep_chrom;
                best_fitness_d = keep_fit;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_FIRST;
            par_valid_q    <= 1'b0;
            parent1_q      <= '0;
            parent2_q      <= '0;
            pair_count_q   <= '0;
            best_valid_q   <= 1'b0;
            best_chrom_q   <= '0;
            best_fitness_q <= '0;
        end else begin
            state_q        <= state_d;
            par_valid_q    <= par_valid_d;
            parent1_q      <= parent1_d;
            parent2_q      <= parent2_d;
            pair_count_q   <= pair_count_d;
            best_valid_q   <= best_valid_d;
            best_chrom_q   <= best_chrom_d;
            best_fitness_q <= best_fitness_d;
        end
    end

    assign par_valid    = par_valid_q;
    assign parent1      = parent1_q;
    assign parent2      = parent2_q;
    assign pair_count   = pair_count_q;
    assign best_valid   = best_valid_q;
    assign best_chrom   = best_chrom_q;
    assign best_fitness = best_fitness_q;

endmodule

// File: tb/tb_tournament_select.sv
// Directed bench for tournament_select: a maximizing and a minimizing
// instance share the same stimulus.
module tb_tournament_select;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [7:0]  chrom1 = '0;
    logic signed [7:0]  chrom2 = '0;
    logic signed [26:0] fitness1 = '0;
    logic signed [26:0] fitness2 = '0;
    logic               par_ready = 1'b0;
    logic               clear_best = 1'b0;

    logic               mx_in_ready, mx_par_valid, mx_best_valid;
    logic signed [7:0]  mx_parent1, mx_parent2, mx_best_chrom;
    logic [15:0]        mx_pair_count;
    logic signed [26:0] mx_best_fitness;

    logic               mn_in_ready, mn_par_valid, mn_best_valid;
    logic signed [7:0]  mn_parent1, mn_parent2, mn_best_chrom;
    logic [15:0]        mn_pair_count;
    logic signed [26:0] mn_best_fitness;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tournament_select #(.CHROM_W(8), .FIT_W(27), .MAXIMIZE(1'b1)) dut_max (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(mx_in_ready),
        .chrom1(chrom1), .chrom2(chrom2), .fitness1(fitness1), .fitness2(fitness2),
        .par_valid(mx_par_valid), .par_ready(par_ready),
        .parent1(mx_parent1), .parent2(mx_parent2), .pair_count(mx_pair_count),
        .clear_best(clear_best), .best_valid(mx_best_valid),
        .best_chrom(mx_best_chrom), .best_fitness(mx_best_fitness)
    );

    tournament_select #(.CHROM_W(8), .FIT_W(27), .MAXIMIZE(1'b0)) dut_min (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(mn_in_ready),
        .chrom1(chrom1), .chrom2(chrom2), .fitness1(fitness1), .fitness2(fitness2),
        .par_valid(mn_par_valid), .par_ready(par_ready),
        .parent1(mn_parent1), .parent2(mn_parent2), .pair_count(mn_pair_count),
        .clear_best(clear_best), .best_valid(mn_best_valid),
        .best_chrom(mn_best_chrom), .best_fitness(mn_best_fitness)
    );

    // Present one scored pair for exactly one clock edge, leave time at edge+1.
    task automatic send_pair(input logic signed [7:0] c1, input logic signed [26:0] f1,
                             input logic signed [7:0] c2, input logic signed [26:0] f2);
        @(negedge clk);
        chrom1 = c1; fitness1 = f1; chrom2 = c2; fitness2 = f2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("pair (%0d,%0d)/(%0d,%0d) presented", c1, f1, c2, f2);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mx_par_valid !== 1'b0) begin failures++; $display("FAIL reset_par_valid got=%0b exp=0", mx_par_valid); end
        checks++; if (mx_best_valid !== 1'b0) begin failures++; $display("FAIL reset_best_valid got=%0b exp=0", mx_best_valid); end
        checks++; if (mx_pair_count !== 16'd0) begin failures++; $display("FAIL reset_pair_count got=%0d exp=0", mx_pair_count); end
        checks++; if (mx_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", mx_in_ready); end
        checks++; if (mx_parent1 !== 8'sd0 || mx_parent2 !== 8'sd0) begin failures++; $display("FAIL reset_parents got=%0d,%0d exp=0,0", mx_parent1, mx_parent2); end
        checks++; if (mx_best_fitness !== 27'sd0) begin failures++; $display("FAIL reset_best_fitness got=%0d exp=0", mx_best_fitness); end
        @(negedge clk);
        reset = 1'b0;
        $display("reset done");
    endtask

    task automatic test_basic;
        par_ready = 1'b1;
        send_pair(8'sd0, 27'sd500, 8'sd20, 27'sd2500);
        checks++; if (mx_in_ready !== 1'b1 || mx_par_valid !== 1'b0) begin failures++; $display("FAIL basic_first got=rdy%0b/pv%0b exp=rdy1/pv0", mx_in_ready, mx_par_valid); end
        send_pair(-8'sd5, 27'sd0, 8'sd30, 27'sd14000);
        checks++; if (mx_par_valid !== 1'b1) begin failures++; $display("FAIL basic_par_valid got=%0b exp=1", mx_par_valid); end
        checks++; if (mx_parent1 !== 8'sd20 || mx_parent2 !== 8'sd30) begin failures++; $display("FAIL basic_parents got=%0d,%0d exp=20,30", mx_parent1, mx_parent2); end
        checks++; if (mx_in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_out got=%0b exp=0", mx_in_ready); end
        @(posedge clk);
        #1;
        checks++; if (mx_pair_count !== 16'd1 || mx_par_valid !== 1'b0 || mx_in_ready !== 1'b1) begin failures++; $display("FAIL basic_handshake got=cnt%0d/pv%0b/rdy%0b exp=cnt1/pv0/rdy1", mx_pair_count, mx_par_valid, mx_in_ready); end
        checks++; if (mx_best_chrom !== 8'sd30 || mx_best_fitness !== 27'sd14000 || mx_best_valid !== 1'b1) begin failures++; $display("FAIL basic_best got=%0d/%0d/%0b exp=30/14000/1", mx_best_chrom, mx_best_fitness, mx_best_valid); end
        $display("basic pair checked");
    endtask

    task automatic test_tie_neg;
        par_ready = 1'b0;
        send_pair(8'sd10, 27'sd0, -8'sd5, 27'sd0);
        send_pair(-8'sd20, -27'sd13500, 8'sd0, 27'sd500);
        checks++; if (mx_parent1 !== 8'sd10 || mx_parent2 !== 8'sd0) begin failures++; $display("FAIL tie_neg_max got=%0d,%0d exp=10,0", mx_parent1, mx_parent2); end
        checks++; if (mn_parent1 !== 8'sd10 || mn_parent2 !== -8'sd20) begin failures++; $display("FAIL tie_neg_min got=%0d,%0d exp=10,-20", mn_parent1, mn_parent2); end
        checks++; if (mn_best_chrom !== -8'sd20 || mn_best_fitness !== -27'sd13500) begin failures++; $display("FAIL tie_neg_min_best got=%0d/%0d exp=-20/-13500", mn_best_chrom, mn_best_fitness); end
        checks++; if (mx_best_chrom !== 8'sd30 || mx_best_fitness !== 27'sd14000) begin failures++; $display("FAIL tie_neg_max_best got=%0d/%0d exp=30/14000", mx_best_chrom, mx_best_fitness); end
        @(negedge clk);
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mx_pair_count !== 16'd2) begin failures++; $display("FAIL tie_neg_count got=%0d exp=2", mx_pair_count); end
        $display("tie and negatives checked");
    endtask

    task automatic test_backpressure;
        par_ready = 1'b0;
        send_pair(8'sd1, 27'sd100, 8'sd2, 27'sd200);
        send_pair(8'sd3, 27'sd300, 8'sd4, 27'sd50);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chrom1 = 8'sd7; fitness1 = 27'sd20000; chrom2 = 8'sd8; fitness2 = 27'sd30000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++; if (mx_par_valid !== 1'b1 || mx_parent1 !== 8'sd2 || mx_parent2 !== 8'sd3 || mx_in_ready !== 1'b0) begin failures++; $display("FAIL backpressure_hold%0d got=pv%0b p%0d,%0d rdy%0b exp=pv1 p2,3 rdy0", i, mx_par_valid, mx_parent1, mx_parent2, mx_in_ready); end
            $display("backpressure cycle %0d", i);
        end
        checks++; if (mx_best_chrom !== 8'sd30 || mx_best_fitness !== 27'sd14000) begin failures++; $display("FAIL backpressure_not_consumed got=%0d/%0d exp=30/14000", mx_best_chrom, mx_best_fitness); end
        @(negedge clk);
        in_valid = 1'b0;
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mx_par_valid !== 1'b0 || mx_in_ready !== 1'b1 || mx_pair_count !== 16'd3) begin failures++; $display("FAIL backpressure_release got=pv%0b rdy%0b cnt%0d exp=pv0 rdy1 cnt3", mx_par_valid, mx_in_ready, mx_pair_count); end
    endtask

    task automatic test_reset_mid;
        par_ready = 1'b0;
        send_pair(8'sd20, 27'sd2500, 8'sd0, 27'sd500);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_pair(8'sd0, 27'sd500, -8'sd100, -27'sd50);
        send_pair(-8'sd5, 27'sd0, -8'sd100, -27'sd50);
        checks++; if (mx_par_valid !== 1'b1 || mx_parent1 !== 8'sd0 || mx_parent2 !== -8'sd5) begin failures++; $display("FAIL reset_mid_parents got=pv%0b p%0d,%0d exp=pv1 p0,-5", mx_par_valid, mx_parent1, mx_parent2); end
        checks++; if (mx_best_chrom !== 8'sd0 || mx_best_fitness !== 27'sd500) begin failures++; $display("FAIL reset_mid_best got=%0d/%0d exp=0/500", mx_best_chrom, mx_best_fitness); end
        @(negedge clk);
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mx_pair_count !== 16'd1) begin failures++; $display("FAIL reset_mid_count got=%0d exp=1", mx_pair_count); end
        $display("reset mid-operation checked");
    endtask

    task automatic test_clear_best;
        par_ready = 1'b0;
        send_pair(8'sd30, 27'sd14000, 8'sd1, 27'sd1);
        checks++; if (mx_best_chrom !== 8'sd30 || mx_best_fitness !== 27'sd14000) begin failures++; $display("FAIL clear_setup got=%0d/%0d exp=30/14000", mx_best_chrom, mx_best_fitness); end
        @(negedge clk);
        clear_best = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mx_best_valid !== 1'b0 || mx_best_chrom !== 8'sd30 || mx_best_fitness !== 27'sd14000) begin failures++; $display("FAIL clear_alone got=%0b/%0d/%0d exp=0/30/14000", mx_best_valid, mx_best_chrom, mx_best_fitness); end
        send_pair(8'sd0, 27'sd500, -8'sd5, 27'sd0);
        clear_best = 1'b0;
        checks++; if (mx_best_valid !== 1'b1 || mx_best_chrom !== 8'sd0 || mx_best_fitness !== 27'sd500) begin failures++; $display("FAIL clear_with_accept got=%0b/%0d/%0d exp=1/0/500", mx_best_valid, mx_best_chrom, mx_best_fitness); end
        checks++; if (mx_par_valid !== 1'b1 || mx_parent1 !== 8'sd30 || mx_parent2 !== 8'sd0) begin failures++; $display("FAIL clear_parents got=pv%0b p%0d,%0d exp=pv1 p30,0", mx_par_valid, mx_parent1, mx_parent2); end
        @(negedge clk);
        force dut_max.pair_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_max.pair_count_q;
        @(negedge clk);
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mx_pair_count !== 16'h0000 || mx_par_valid !== 1'b0) begin failures++; $display("FAIL count_wrap got=%0h/pv%0b exp=0/pv0", mx_pair_count, mx_par_valid); end
        $display("clear_best and wrap checked");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_neg();
        test_backpressure();
        test_reset_mid();
        test_clear_best();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
